// File: rtl/std_mem_pkg.sv
// Shared control-state type for the std_mem family of sequential memories.
package std_mem_pkg;

  typedef enum logic {
    SWEEP = 1'b0,
    READY = 1'b1
  } mem_state_e;

endpackage

// File: rtl/std_mem_init_ctr.sv
// Word index for the zero-init sweep: counts 0..SIZE-1 while en is high, flags the last word.
// Latency: index advances one word per enabled cycle; no backpressure.
module std_mem_init_ctr #(
  parameter int SIZE     = 16,
  parameter int IDX_SIZE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  output logic [IDX_SIZE-1:0] idx,
  output logic                last
);

  assign last = (idx == IDX_SIZE'(SIZE - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= '0;
    end else if (en) begin
      idx <= last ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/std_seq_mem_d1.sv
// Single-port word memory, 1-cycle registered read, done/oob_err pulses; optional zero sweep (STD_MEM_INIT_SWEEP_EN).
// Requests are taken only while ready=1; anything presented while not ready is dropped silently.
module std_seq_mem_d1
  import std_mem_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 16,
  parameter int IDX_SIZE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_SIZE-1:0] addr0,
  input  logic [WIDTH-1:0]    write_data,
  input  logic                write_en,
  input  logic                read_en,
  output logic [WIDTH-1:0]    read_data,
  output logic                done,
  output logic                ready,
  output logic                oob_err
);

  (* keep *) logic [WIDTH-1:0] mem [SIZE];

  mem_state_e          state;
  mem_state_e          state_nxt;
  logic                acc;
  logic                in_bounds;
  logic                mem_we;
  logic [IDX_SIZE-1:0] mem_wa;
  logic [WIDTH-1:0]    mem_wd;

  // Extra bit so SIZE == 2**IDX_SIZE still compares correctly.
  assign in_bounds = ({1'b0, addr0} < (IDX_SIZE + 1)'(SIZE));
  assign ready     = (state == READY);
  assign acc       = ready & (read_en | write_en);

`ifdef STD_MEM_INIT_SWEEP_EN
  logic [IDX_SIZE-1:0] sweep_idx;
  logic                sweep_last;

  std_mem_init_ctr #(
    .SIZE     (SIZE),
    .IDX_SIZE (IDX_SIZE)
  ) u_init_ctr (
    .clk   (clk),
    .reset (reset),
    .en    (state == SWEEP),
    .idx   (sweep_idx),
    .last  (sweep_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= SWEEP;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == SWEEP && sweep_last) state_nxt = READY;
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= READY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = READY;
  end
`endif

  always_comb begin
    mem_we = ~reset & acc & write_en & in_bounds;
    mem_wa = addr0;
    mem_wd = write_data;
`ifdef STD_MEM_INIT_SWEEP_EN
    if (state == SWEEP) begin
      mem_we = 1'b1;
      mem_wa = sweep_idx;
      mem_wd = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // Read samples the array before this edge's write lands, so read+write returns the old word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_data <= '0;
      done      <= 1'b0;
      oob_err   <= 1'b0;
    end else begin
      done    <= acc;
      oob_err <= acc & ~in_bounds;
      if (acc & read_en) read_data <= in_bounds ? mem[addr0] : '0;
    end
  end

endmodule

// File: tb/tb_std_seq_mem_d1.sv
// Directed bench for std_seq_mem_d1: SIZE=16 and SIZE=12 instances share stimulus, scoreboard per instance.
// Adapts to STD_MEM_INIT_SWEEP_EN for sweep timing and post-reset contents.
module tb_std_seq_mem_d1;

`ifdef STD_MEM_INIT_SWEEP_EN
  localparam bit SWEEP_ON = 1'b1;
`else
  localparam bit SWEEP_ON = 1'b0;
`endif

  typedef struct {
    logic [31:0] rd;
    logic        done;
    logic        oob;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [3:0]  addr0;
  logic [31:0] write_data;
  logic        write_en;
  logic        read_en;
  logic [31:0] rd_o   [2];
  logic        done_o [2];
  logic        rdy_o  [2];
  logic        oob_o  [2];

  int          errors;
  int          checks;
  exp_t        sbq [$];
  int          size_c [2];
  int          left   [2];
  logic [31:0] last_rd [2];
  logic [31:0] mm [2][16];

  std_seq_mem_d1 u_dut16 (
    .clk        (clk),
    .reset      (reset),
    .addr0      (addr0),
    .write_data (write_data),
    .write_en   (write_en),
    .read_en    (read_en),
    .read_data  (rd_o[0]),
    .done       (done_o[0]),
    .ready      (rdy_o[0]),
    .oob_err    (oob_o[0])
  );

  std_seq_mem_d1 #(
    .WIDTH    (32),
    .SIZE     (12),
    .IDX_SIZE (4)
  ) u_dut12 (
    .clk        (clk),
    .reset      (reset),
    .addr0      (addr0),
    .write_data (write_data),
    .write_en   (write_en),
    .read_en    (read_en),
    .read_data  (rd_o[1]),
    .done       (done_o[1]),
    .ready      (rdy_o[1]),
    .oob_err    (oob_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, predict both instances, compare after the edge.
  task automatic step(input logic re, input logic we, input logic [3:0] a, input logic [31:0] d);
    exp_t e;
    logic rdy, acc, inb;
    read_en    = re;
    write_en   = we;
    addr0      = a;
    write_data = d;
    for (int i = 0; i < 2; i++) begin
      rdy = (left[i] == 0);
      check($sformatf("ready[%0d] a=%0d", i, a), 32'(rdy_o[i]), 32'(rdy));
      acc = rdy && (re || we);
      inb = int'(a) < size_c[i];
      e.done = acc;
      e.oob  = acc && !inb;
      if (acc && re) last_rd[i] = inb ? mm[i][a] : 32'h0;
      e.rd = last_rd[i];
      if (acc && we && inb) mm[i][a] = d;
      if (!rdy) left[i]--;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_empty[%0d] observed=0 entries expected=1", i);
      end else begin
        e = sbq.pop_front();
        check($sformatf("read_data[%0d] a=%0d", i, a), rd_o[i], e.rd);
        check($sformatf("done[%0d] a=%0d", i, a), 32'(done_o[i]), 32'(e.done));
        check($sformatf("oob_err[%0d] a=%0d", i, a), 32'(oob_o[i]), 32'(e.oob));
      end
    end
  endtask

  // Asynchronous assert (outputs must clear without a clock edge), release after two edges.
  task automatic do_reset();
    reset    = 1'b1;
    read_en  = 1'b0;
    write_en = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_read_data[%0d]", i), rd_o[i], 32'h0);
      check($sformatf("rst_done[%0d]", i), 32'(done_o[i]), 32'h0);
      check($sformatf("rst_oob_err[%0d]", i), 32'(oob_o[i]), 32'h0);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      left[i]    = SWEEP_ON ? size_c[i] : 0;
      last_rd[i] = 32'h0;
      for (int j = 0; j < 16; j++) mm[i][j] = SWEEP_ON ? 32'h0 : 32'hx;
    end
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    size_c[0]  = 16;
    size_c[1]  = 12;
    reset      = 1'b1;
    read_en    = 1'b0;
    write_en   = 1'b0;
    addr0      = '0;
    write_data = '0;

    do_reset();

    if (SWEEP_ON) begin
      // Interrupt the sweep at cycle 7; requests during the sweep must be ignored.
      for (int k = 0; k < 7; k++) step(1'b1, 1'b1, 4'(k), 32'hFFFF_0000 + 32'(k));
      do_reset();
      for (int k = 0; k < 16; k++) step(1'b1, 1'b0, 4'd7, 32'h0);
      for (int k = 0; k < 16; k++) step(1'b1, 1'b0, 4'(k), 32'h0);
    end

    // Back-to-back preload: done must stay high every cycle.
    for (int k = 0; k < 16; k++) step(1'b0, 1'b1, 4'(k), 32'hA000_0000 + 32'(k));

    step(1'b0, 1'b1, 4'd3, 32'hDEAD_BEEF);
    step(1'b1, 1'b0, 4'd3, 32'h0);

    step(1'b0, 1'b1, 4'd5, 32'h11);
    step(1'b1, 1'b1, 4'd5, 32'h22);
    step(1'b0, 1'b0, 4'd0, 32'h0);
    step(1'b1, 1'b0, 4'd5, 32'h0);

    // Out of bounds for the 12-word instance only.
    step(1'b0, 1'b1, 4'd13, 32'h0BAD_0BAD);
    step(1'b0, 1'b0, 4'd0, 32'h0);
    step(1'b1, 1'b0, 4'd13, 32'h0);
    step(1'b1, 1'b0, 4'd15, 32'h0);
    for (int k = 0; k < 16; k++) step(1'b1, 1'b0, 4'(k), 32'h0);
    step(1'b0, 1'b0, 4'd2, 32'h1234_5678);

    // Reset right after an accepted read: done and read_data must drop at once.
    step(1'b1, 1'b0, 4'd3, 32'h0);
    do_reset();
    if (SWEEP_ON) begin
      for (int k = 0; k < 16; k++) step(1'b0, 1'b0, 4'd0, 32'h0);
    end
    step(1'b0, 1'b1, 4'd0, 32'h5555_AAAA);
    step(1'b1, 1'b0, 4'd0, 32'h0);
    step(1'b0, 1'b0, 4'd0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/std_seq_mem_d1.md
STD_SEQ_MEM_D1 -- requirements
Module: std_seq_mem_d1

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter SIZE, default 16, number of words.
REQ-003 SHALL have parameter IDX_SIZE, default 4, address width; IDX_SIZE >= clog2(SIZE) is required.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1, the reset; asynchronous, active-high.
REQ-007 SHALL have port addr0, input, IDX_SIZE, word address for both read and write.
REQ-008 SHALL have port write_data, input, WIDTH, write word.
REQ-009 SHALL have port write_en, input, 1, write request, sampled at clk edge.
REQ-010 SHALL have port read_en, input, 1, read request, sampled at clk edge.
REQ-011 SHALL have port read_data, output, WIDTH, registered read result.
REQ-012 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-013 SHALL have port ready, output, 1, high when requests are accepted.
REQ-014 SHALL have port oob_err, output, 1, one-cycle pulse on an out-of-bounds access.

Function
REQ-015 SHALL accept a request only in a cycle where ready=1 and (read_en|write_en)=1; otherwise it is ignored with no side effect.
REQ-016 SHALL commit an accepted in-bounds write to mem[addr0] at the accepting edge, with done=1 in the following cycle only.
REQ-017 SHALL load read_data with mem[addr0] at the accepting edge of a read, with done=1 in the following cycle; latency is exactly 1 cycle.
REQ-018 SHALL hold read_data unchanged until the next accepted read or reset.
REQ-019 SHALL, on simultaneous read_en and write_en, perform both: the write commits and read_data returns the pre-write (old) word; done pulses once.
REQ-020 SHALL treat addr0 >= SIZE as out of bounds: the write is dropped, read_data loads 0, and done and oob_err both pulse for one cycle.
REQ-021 SHALL accept back-to-back requests every cycle; done is then high continuously, one pulse per request.
REQ-022 SHALL implement control states SWEEP and READY; ready=1 exactly in READY.
REQ-023 SHALL, in SWEEP, write 0 to one word per cycle via a counter from 0 to SIZE-1, then enter READY on the edge after word SIZE-1 is written.

Reset
REQ-024 SHALL, while reset=1, drive read_data=0, done=0, oob_err=0, and clear the sweep counter.
REQ-025 SHALL enter SWEEP (macro defined) or READY (macro undefined) on reset.
REQ-026 SHALL, on reset mid-operation or mid-sweep, abandon the in-flight request with no done pulse, and restart the sweep from word 0.

Configuration
REQ-027 SHALL compile the zero-init sweep only when macro STD_MEM_INIT_SWEEP_EN is defined.
REQ-028 SHALL, with the macro defined, keep ready=0 for exactly SIZE cycles after reset release, with all words reading 0 afterwards.
REQ-029 SHALL, without the macro, omit SWEEP and the counter entirely, set ready=1 from the first cycle after reset, and leave memory contents undefined.

Structure
REQ-030 SHALL place the control-state enum typedef (SWEEP, READY) in shared package std_mem_pkg.
REQ-031 SHALL implement the sweep counter as sub-module std_mem_init_ctr, parameterised by SIZE and IDX_SIZE, with outputs for the current index and last-word.
REQ-032 SHALL mark the storage array keep so synthesis does not prune it.

Verification
REQ-033 SHALL cover sweep: macro on, SIZE=16, reset released -> ready=0 for 16 cycles then 1; a read of every address returns 0.
REQ-034 SHALL cover write-then-read: write 0xDEADBEEF at addr 3, then read addr 3 -> done pulses each cycle; read_data=0xDEADBEEF one cycle after the read.
REQ-035 SHALL cover simultaneous access: mem[5]=0x11, then read_en=write_en=1 at addr 5 with data 0x22 -> read_data=0x11, a later read gives 0x22, and a single done pulse.
REQ-036 SHALL cover out-of-bounds: SIZE=12, IDX_SIZE=4, write addr 13 -> done=1 and oob_err=1 for one cycle; all words are unchanged.
REQ-037 SHALL cover reset mid-sweep: reset asserted at sweep cycle 7 -> outputs are 0 immediately; after release, ready=0 for a full 16 cycles.
REQ-038 SHALL cover macro off: reset release -> ready=1 next cycle; a write at addr 0 then read at addr 0 returns the written value.
